pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. It takes hazard information from the ID, EX, MEM and WB stages and drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It implements a halt-drain FSM for ecall/ebreak. It also keeps saturating stall and flush performance counters.

Parameters:
ADDR_WIDTH, 5, register address width
CNT_WIDTH, 32, width of each performance counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
ID_rs1_addr_i  in  ADDR_WIDTH  rs1 of the instruction in ID
ID_rs2_addr_i  in  ADDR_WIDTH  rs2 of the instruction in ID
ID_rs1_used_i  in  1  ID instruction reads rs1
ID_rs2_used_i  in  1  ID instruction reads rs2
ID_halt_i  in  1  ID holds ecall/ebreak
EX_rd_addr_i  in  ADDR_WIDTH  rd of the instruction in EX
EX_RegWrite_i  in  1  EX instruction writes rd
EX_MemRead_i  in  1  EX instruction is a load
EX_branch_taken_i  in  1  taken branch or jump resolved in EX
MEM_req_i  in  1  MEM stage has a data-memory access pending
MEM_ready_i  in  1  data memory completes the access this cycle
resume_i  in  1  release from the HALTED state
cnt_clr_i  in  1  synchronous clear of both counters
PC_en_o  out  1  PC register update enable
PC_sel_o  out  1  1 = load branch target, 0 = PC+4
IF_ID_en_o  out  1  IF/ID register enable
IF_ID_flush_o  out  1  insert bubble into IF/ID
ID_EX_en_o  out  1  ID/EX register enable
ID_EX_flush_o  out  1  insert bubble into ID/EX
EX_MEM_en_o  out  1  EX/MEM register enable
MEM_WB_flush_o  out  1  insert bubble into MEM/WB
halted_o  out  1  core halted; registered
stall_cnt_o  out  CNT_WIDTH  stall cycle count
flush_cnt_o  out  CNT_WIDTH  branch flush count

Behaviour:
- Signal definitions (combinational):
  - mem_wait = MEM_req_i & ~MEM_ready_i.
  - load_use = EX_MemRead_i & EX_RegWrite_i & (EX_rd_addr_i != 0) & ((ID_rs1_used_i & rs1 == EX_rd) | (ID_rs2_used_i & rs2 == EX_rd)).
- Default outputs: every en = 1, every flush = 0, PC_sel_o = 0. All control outputs are combinational from state and inputs.
- Priority, highest first: HALTED > mem_wait > branch > load_use > halt entry.
- mem_wait: PC, IF_ID, ID_EX and EX_MEM enables = 0; MEM_WB_flush_o = 1; all other flushes = 0. Holds for as many cycles as MEM_ready_i stays low.
- branch, RUN state only: PC_sel_o = 1, IF_ID_flush_o = 1, ID_EX_flush_o = 1. Any load_use or ID_halt_i in the same cycle is wrong-path and is ignored.
- load_use: PC_en_o = 0, IF_ID_en_o = 0, ID_EX_flush_o = 1. Lasts exactly one cycle without mem_wait; the following cycle re-evaluates.
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
  - RUN -> DRAIN: ID_halt_i & ~mem_wait & ~EX_branch_taken_i & ~load_use. In that cycle PC_en_o = 0; the halt instruction advances into ID/EX.
  - DRAIN: PC_en_o = 0, IF_ID_flush_o = 1. EX_branch_taken_i is ignored. A 2-bit drain counter loads 3 on entry and decrements on each non-mem_wait cycle.
  - DRAIN -> HALTED: counter = 1 and ~mem_wait.
  - HALTED: every en = 0, every flush = 0, halted_o = 1 (registered, asserted the cycle after entry).
  - HALTED -> RUN: resume_i. The next cycle has normal outputs and halted_o = 0. resume_i is ignored outside HALTED.
- Counters:
  - stall_cnt_o increments on each cycle of (mem_wait | load_use) while not HALTED.
  - flush_cnt_o increments on each cycle a branch flush is actually applied (RUN, ~mem_wait, EX_branch_taken_i).
  - Both saturate at all-ones.
  - cnt_clr_i zeroes both and overrides any increment in the same cycle.
- Reset (async, rst_n = 0): state = RUN, drain counter = 0, halted_o = 0, stall_cnt_o = 0, flush_cnt_o = 0. Reset asserted mid-DRAIN or in HALTED returns the FSM to RUN immediately.

Decomposition:
- Package defines gains ctrl_state_e {RUN, DRAIN, HALTED} and the constant DRAIN_CYCLES = 3.
- One sub-module, sat_counter (parameter WIDTH; inputs inc, clr), instantiated twice for the two performance counters.

Test Plan:
- Load-use: EX = lw x5 (MemRead = 1, RegWrite = 1, rd = 5); ID rs1 = 5, used -> exactly one cycle with PC_en_o = 0, IF_ID_en_o = 0, ID_EX_flush_o = 1; stall_cnt_o = 1. Repeat with rd = 0 -> no stall.
- Branch: EX_branch_taken_i = 1 while load_use and ID_halt_i are also true -> PC_sel_o = 1, IF_ID_flush_o = 1, ID_EX_flush_o = 1, no stall; flush_cnt_o = 1; state stays RUN.
- Memory wait: MEM_req_i = 1, MEM_ready_i = 0 for 4 cycles together with load_use -> 4 cycles of frozen enables and MEM_WB_flush_o = 1; stall_cnt_o = 4; then normal operation once ready.
- Halt: ID_halt_i pulse -> DRAIN; halted_o = 1 after 4 cycles with no mem_wait. Inject 2 mem_wait cycles during DRAIN -> halted_o delayed by 2 cycles. resume_i -> RUN, PC_en_o = 1.
- Saturation and clear: with CNT_WIDTH = 4, 20 stall cycles -> stall_cnt_o = 15. cnt_clr_i asserted together with a stall -> 0.
- Reset mid-DRAIN: rst_n low for 1 cycle -> state RUN, halted_o = 0, both counters = 0, default outputs.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

  localparam int unsigned DRAIN_CYCLES = 3;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard priority, halt-drain FSM
// and saturating stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ID_rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] ID_rs2_addr_i,
  input  logic                  ID_rs1_used_i,
  input  logic                  ID_rs2_used_i,
  input  logic                  ID_halt_i,
  input  logic [ADDR_WIDTH-1:0] EX_rd_addr_i,
  input  logic                  EX_RegWrite_i,
  input  logic                  EX_MemRead_i,
  input  logic                  EX_branch_taken_i,
  input  logic                  MEM_req_i,
  input  logic                  MEM_ready_i,
  input  logic                  resume_i,
  input  logic                  cnt_clr_i,
  output logic                  PC_en_o,
  output logic                  PC_sel_o,
  output logic                  IF_ID_en_o,
  output logic                  IF_ID_flush_o,
  output logic                  ID_EX_en_o,
  output logic                  ID_EX_flush_o,
  output logic                  EX_MEM_en_o,
  output logic                  MEM_WB_flush_o,
  output logic                  halted_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

  ctrl_state_e r_state;
  logic [1:0]  r_drain_cnt;
  logic        r_halted;

  logic w_mem_wait;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;
  logic w_branch;
  logic w_halt_entry;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_mem_wait   = MEM_req_i & ~MEM_ready_i;
  assign w_rs1_hit    = ID_rs1_used_i & (ID_rs1_addr_i == EX_rd_addr_i);
  assign w_rs2_hit    = ID_rs2_used_i & (ID_rs2_addr_i == EX_rd_addr_i);
  assign w_load_use   = EX_MemRead_i & EX_RegWrite_i & (EX_rd_addr_i != '0) & (w_rs1_hit | w_rs2_hit);
  assign w_branch     = (r_state == RUN) & EX_branch_taken_i;
  assign w_halt_entry = (r_state == RUN) & ID_halt_i & ~w_mem_wait & ~EX_branch_taken_i & ~w_load_use;

  assign w_stall_inc  = (r_state != HALTED) & (w_mem_wait | w_load_use);
  assign w_flush_inc  = w_branch & ~w_mem_wait;

  // Priority chain: HALTED > mem_wait > branch > load_use > drain/halt entry.
  always_comb begin
    PC_en_o        = 1'b1;
    PC_sel_o       = 1'b0;
    IF_ID_en_o     = 1'b1;
    IF_ID_flush_o  = 1'b0;
    ID_EX_en_o     = 1'b1;
    ID_EX_flush_o  = 1'b0;
    EX_MEM_en_o    = 1'b1;
    MEM_WB_flush_o = 1'b0;
    if (r_state == HALTED) begin
      PC_en_o     = 1'b0;
      IF_ID_en_o  = 1'b0;
      ID_EX_en_o  = 1'b0;
      EX_MEM_en_o = 1'b0;
    end else if (w_mem_wait) begin
      PC_en_o        = 1'b0;
      IF_ID_en_o     = 1'b0;
      ID_EX_en_o     = 1'b0;
      EX_MEM_en_o    = 1'b0;
      MEM_WB_flush_o = 1'b1;
    end else if (w_branch) begin
      PC_sel_o      = 1'b1;
      IF_ID_flush_o = 1'b1;
      ID_EX_flush_o = 1'b1;
    end else if (w_load_use) begin
      PC_en_o       = 1'b0;
      IF_ID_en_o    = 1'b0;
      ID_EX_flush_o = 1'b1;
    end else if (r_state == DRAIN) begin
      PC_en_o       = 1'b0;
      IF_ID_flush_o = 1'b1;
    end else if (w_halt_entry) begin
      PC_en_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_halt_entry) begin
            r_state     <= DRAIN;
            r_drain_cnt <= 2'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (!w_mem_wait) begin
            if (r_drain_cnt == 2'd1) begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end
            r_drain_cnt <= r_drain_cnt - 2'd1;
          end
        end
        HALTED: begin
          if (resume_i) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign halted_o = r_halted;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .clr   (cnt_clr_i),
    .cnt   (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_inc),
    .clr   (cnt_clr_i),
    .cnt   (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ID_rs1_addr_i = '0, ID_rs2_addr_i = '0, EX_rd_addr_i = '0;
  logic          ID_rs1_used_i = 0, ID_rs2_used_i = 0, ID_halt_i = 0;
  logic          EX_RegWrite_i = 0, EX_MemRead_i = 0, EX_branch_taken_i = 0;
  logic          MEM_req_i = 0, MEM_ready_i = 0, resume_i = 0, cnt_clr_i = 0;
  logic          PC_en_o, PC_sel_o, IF_ID_en_o, IF_ID_flush_o, ID_EX_en_o, ID_EX_flush_o;
  logic          EX_MEM_en_o, MEM_WB_flush_o, halted_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  pipeline_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1_addr_i(ID_rs1_addr_i), .ID_rs2_addr_i(ID_rs2_addr_i),
    .ID_rs1_used_i(ID_rs1_used_i), .ID_rs2_used_i(ID_rs2_used_i), .ID_halt_i(ID_halt_i),
    .EX_rd_addr_i(EX_rd_addr_i), .EX_RegWrite_i(EX_RegWrite_i), .EX_MemRead_i(EX_MemRead_i),
    .EX_branch_taken_i(EX_branch_taken_i), .MEM_req_i(MEM_req_i), .MEM_ready_i(MEM_ready_i),
    .resume_i(resume_i), .cnt_clr_i(cnt_clr_i),
    .PC_en_o(PC_en_o), .PC_sel_o(PC_sel_o), .IF_ID_en_o(IF_ID_en_o), .IF_ID_flush_o(IF_ID_flush_o),
    .ID_EX_en_o(ID_EX_en_o), .ID_EX_flush_o(ID_EX_flush_o), .EX_MEM_en_o(EX_MEM_en_o),
    .MEM_WB_flush_o(MEM_WB_flush_o), .halted_o(halted_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 = running, 1 = draining, 2 = halted; m_left = drain cycles still owed.
  int   m_mode, m_left, m_stall, m_flush;
  bit   m_halted, m_mw, m_lu, m_br;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0; m_halted = 0;
  endtask

  task automatic check_now();
    bit pe = 1, ps = 0, ie = 1, ifl = 0, de = 1, dfl = 0, xe = 1, wfl = 0;
    bit hit1, hit2;
    m_mw = MEM_req_i && !MEM_ready_i;
    hit1 = ID_rs1_used_i && (ID_rs1_addr_i == EX_rd_addr_i);
    hit2 = ID_rs2_used_i && (ID_rs2_addr_i == EX_rd_addr_i);
    m_lu = EX_MemRead_i && EX_RegWrite_i && (EX_rd_addr_i != 0) && (hit1 || hit2);
    m_br = EX_branch_taken_i;
    if (m_mode == 2) begin
      pe = 0; ie = 0; de = 0; xe = 0;
    end else if (m_mw) begin
      pe = 0; ie = 0; de = 0; xe = 0; wfl = 1;
    end else if (m_mode == 0 && m_br) begin
      ps = 1; ifl = 1; dfl = 1;
    end else if (m_lu) begin
      pe = 0; ie = 0; dfl = 1;
    end else if (m_mode == 1) begin
      pe = 0; ifl = 1;
    end else if (ID_halt_i) begin
      pe = 0;
    end
    chk("ctl", {23'b0, PC_en_o, PC_sel_o, IF_ID_en_o, IF_ID_flush_o, ID_EX_en_o, ID_EX_flush_o,
                EX_MEM_en_o, MEM_WB_flush_o, halted_o},
        {23'b0, pe, ps, ie, ifl, de, dfl, xe, wfl, m_halted});
    chk("stall_cnt", {28'b0, stall_cnt_o}, m_stall);
    chk("flush_cnt", {28'b0, flush_cnt_o}, m_flush);
  endtask

  task automatic model_step();
    bit st_inc, fl_inc;
    st_inc = (m_mode != 2) && (m_mw || m_lu);
    fl_inc = (m_mode == 0) && !m_mw && m_br;
    if (cnt_clr_i) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (st_inc && m_stall < 15) m_stall++;
      if (fl_inc && m_flush < 15) m_flush++;
    end
    case (m_mode)
      0: if (ID_halt_i && !m_mw && !m_br && !m_lu) begin m_mode = 1; m_left = 3; end
      1: if (!m_mw) begin
           if (m_left == 1) begin m_mode = 2; m_halted = 1; end
           else m_left--;
         end
      default: if (resume_i) begin m_mode = 0; m_halted = 0; end
    endcase
  endtask

  // Inputs are set at the falling edge; tick checks, then advances one clock.
  task automatic tick();
    #1 check_now();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    ID_rs1_addr_i = '0; ID_rs2_addr_i = '0; EX_rd_addr_i = '0;
    ID_rs1_used_i = 0; ID_rs2_used_i = 0; ID_halt_i = 0;
    EX_RegWrite_i = 0; EX_MemRead_i = 0; EX_branch_taken_i = 0;
    MEM_req_i = 0; MEM_ready_i = 0; resume_i = 0; cnt_clr_i = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    model_reset();
    #1 check_now();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic load_use(input logic [AW-1:0] rd);
    EX_MemRead_i = 1; EX_RegWrite_i = 1; EX_rd_addr_i = rd;
    ID_rs1_addr_i = rd; ID_rs1_used_i = 1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // load-use on x5, then on x0
    load_use(5'd5); tick();
    idle(); tick();
    chk("lu_stall_once", {28'b0, stall_cnt_o}, 32'd1);
    load_use(5'd0); tick();
    idle(); tick();
    chk("lu_x0_nostall", {28'b0, stall_cnt_o}, 32'd1);

    // taken branch overriding load-use and halt
    do_reset();
    load_use(5'd7); ID_halt_i = 1; EX_branch_taken_i = 1; tick();
    idle(); tick();
    chk("br_flush_cnt", {28'b0, flush_cnt_o}, 32'd1);
    chk("br_no_halt", {31'b0, PC_en_o}, 32'd1);

    // memory wait with load-use pending
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load_use(5'd3); MEM_req_i = 1; MEM_ready_i = 0; tick();
    end
    chk("mw_stall_cnt", {28'b0, stall_cnt_o}, 32'd4);
    idle(); MEM_req_i = 1; MEM_ready_i = 1; tick();
    idle(); tick();

    // halt drain without and with memory waits
    do_reset();
    ID_halt_i = 1; tick(); idle();
    tick(); tick();
    chk("halt_not_yet", {31'b0, halted_o}, 32'd0);
    tick();
    chk("halt_after4", {31'b0, halted_o}, 32'd1);
    tick(); tick();
    resume_i = 1; tick(); idle(); tick();
    ID_halt_i = 1; tick(); idle();
    MEM_req_i = 1; tick(); tick(); idle();
    tick(); tick();
    chk("halt_delayed", {31'b0, halted_o}, 32'd0);
    tick();
    chk("halt_after6", {31'b0, halted_o}, 32'd1);
    resume_i = 1; tick(); idle();
    chk("resume_pc_en", {31'b0, PC_en_o}, 32'd1);
    tick();

    // saturation and clear
    do_reset();
    for (int i = 0; i < 20; i++) begin
      MEM_req_i = 1; tick();
    end
    chk("sat_stall", {28'b0, stall_cnt_o}, 32'd15);
    MEM_req_i = 1; cnt_clr_i = 1; tick(); idle();
    chk("clr_stall", {28'b0, stall_cnt_o}, 32'd0);

    // reset mid-drain
    EX_branch_taken_i = 1; tick(); idle();
    ID_halt_i = 1; tick(); idle(); tick();
    do_reset();
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        ID_rs1_addr_i = AW'($urandom_range(0, 3));
        ID_rs2_addr_i = AW'($urandom_range(0, 3));
        EX_rd_addr_i  = AW'($urandom_range(0, 3));
        ID_rs1_used_i = 1'($urandom);
        ID_rs2_used_i = 1'($urandom);
        EX_RegWrite_i = ($urandom_range(0, 3) != 0);
        EX_MemRead_i  = ($urandom_range(0, 2) == 0);
        ID_halt_i     = ($urandom_range(0, 15) == 0);
        EX_branch_taken_i = ($urandom_range(0, 5) == 0);
        MEM_req_i     = ($urandom_range(0, 3) == 0);
        MEM_ready_i   = 1'($urandom);
        resume_i      = ($urandom_range(0, 3) == 0);
        cnt_clr_i     = ($urandom_range(0, 63) == 0);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
